// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   seq_state_e : sequencer FSM encoding
//   PC_W_DEF    : default program-counter width
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_e;

  localparam int PC_W_DEF = 6;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selector: halt > call > ret > taken branch > pc+1.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is committed.
// Ports:
//   pc       in   PC_W  current program counter
//   halt     in   1     hold the PC (halting after this instruction)
//   call     in   1     jump to br_tgt (link written by the caller)
//   ret      in   1     return to link
//   br_taken in   1     jump to br_tgt
//   br_tgt   in   PC_W  branch/call target
//   link     in   PC_W  saved return address
//   pc_next  out  PC_W  selected next program counter
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic            halt,
  input  logic            call,
  input  logic            ret,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_tgt,
  input  logic [PC_W-1:0] link,
  output logic [PC_W-1:0] pc_next
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  // Increment wraps naturally at 2**PC_W; no overflow flag is wanted.
  logic [PC_W-1:0] pc_inc;
  assign pc_inc = pc + PC_ONE;

  always_comb begin
    pc_next = pc_inc;
    if (halt) begin
      pc_next = pc;
    end else if (call) begin
      pc_next = br_tgt;
    end else if (ret) begin
      pc_next = link;
    end else if (br_taken) begin
      pc_next = br_tgt;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer owning the CPU program counter; imem request in FETCH, waits for datapath in EXEC.
// Latency: fetch takes >=1 cycle (ack may arrive with the request); PC commits on the EXEC exit edge.
// Backpressure: imem_req_o held until imem_ack_i; stall_i blocks EXEC completion while high.
// Optional feature macro: PC_SEQ_LINK_EN adds call_i/ret_i and a one-entry link register.
// Ports:
//   clk          in   1     clock, posedge
//   rst          in   1     asynchronous, active-low reset
//   run_i        in   1     start pulse, honoured in IDLE or HALT
//   imem_req_o   out  1     fetch request (FETCH state)
//   imem_addr_o  out  PC_W  fetch address (= pc_o)
//   imem_ack_i   in   1     instruction available this cycle
//   instr_vld_o  out  1     one-cycle pulse in the first EXEC cycle
//   exec_done_i  in   1     datapath finished current instruction
//   stall_i      in   1     hazard; overrides exec_done_i
//   br_taken_i   in   1     take branch (qualified by exec_done_i)
//   br_tgt_i     in   PC_W  branch/call target
//   halt_i       in   1     halt after this instruction (qualified by exec_done_i)
//   call_i       in   1     (PC_SEQ_LINK_EN) call: link<=pc+1, pc<=br_tgt_i
//   ret_i        in   1     (PC_SEQ_LINK_EN) return: pc<=link
//   pc_o         out  PC_W  current program counter
//   halted_o     out  1     high in HALT
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  output logic            instr_vld_o,
  input  logic            exec_done_i,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_tgt_i,
  input  logic            halt_i,
`ifdef PC_SEQ_LINK_EN
  input  logic            call_i,
  input  logic            ret_i,
`endif
  output logic [PC_W-1:0] pc_o,
  output logic            halted_o
);

  seq_state_e      state;
  seq_state_e      state_nxt;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next;
  logic            vld_q;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] link;

  // An instruction retires only when done is seen with no hazard; a stalled
  // done is simply re-sampled next cycle, so the datapath must hold it.
  logic exec_fire;
  assign exec_fire = (state == EXEC) && exec_done_i && !stall_i;

  // run_i is meaningful only while parked; ignored in FETCH/EXEC.
  logic start;
  assign start = run_i && ((state == IDLE) || (state == HALT));

`ifdef PC_SEQ_LINK_EN
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] link_q;

  assign call = call_i;
  assign ret  = ret_i;
  assign link = link_q;

  // A call that coincides with halt is dropped entirely, link included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      link_q <= RESET_VEC;
    end else if (exec_fire && call_i && !halt_i) begin
      link_q <= pc_q + PC_ONE;
    end
  end
`else
  assign call = 1'b0;
  assign ret  = 1'b0;
  assign link = RESET_VEC;
`endif

  pc_next_mux #(
    .PC_W (PC_W)
  ) u_next_mux (
    .pc       (pc_q),
    .halt     (halt_i),
    .call     (call),
    .ret      (ret),
    .br_taken (br_taken_i),
    .br_tgt   (br_tgt_i),
    .link     (link),
    .pc_next  (pc_next)
  );

  // State register. Reset is asynchronous so a mid-fetch request drops at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (run_i) state_nxt = FETCH;
      end
      FETCH: begin
        if (imem_ack_i) state_nxt = EXEC;
      end
      EXEC: begin
        if (exec_fire) state_nxt = halt_i ? HALT : FETCH;
      end
      HALT: begin
        if (run_i) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. imem_req_o is decoded straight from the state register so
  // it is glitch-free and falls with the asynchronous reset.
  always_comb begin
    imem_req_o  = 1'b0;
    halted_o    = 1'b0;
    case (state)
      FETCH:   imem_req_o = 1'b1;
      HALT:    halted_o   = 1'b1;
      default: begin
        imem_req_o = 1'b0;
        halted_o   = 1'b0;
      end
    endcase
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign instr_vld_o = vld_q;

  // PC moves only on (re)start or when an instruction retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VEC;
    end else if (start) begin
      pc_q <= RESET_VEC;
    end else if (exec_fire) begin
      pc_q <= pc_next;
    end
  end

  // Registered FETCH->EXEC transition gives exactly one pulse, aligned with
  // the first EXEC cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= (state == FETCH) && imem_ack_i;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with an expected-fetch-address scoreboard.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run_i = 1'b0;
  logic       imem_req_o;
  logic [5:0] imem_addr_o;
  logic       imem_ack_i = 1'b0;
  logic       instr_vld_o;
  logic       exec_done_i = 1'b0;
  logic       stall_i = 1'b0;
  logic       br_taken_i = 1'b0;
  logic [5:0] br_tgt_i = '0;
  logic       halt_i = 1'b0;
  logic [5:0] pc_o;
  logic       halted_o;
`ifdef PC_SEQ_LINK_EN
  logic       call_i = 1'b0;
  logic       ret_i = 1'b0;
`endif

  int         tests = 0;
  int         fails = 0;
  logic [5:0] exp_q[$];
  logic [5:0] model_pc = '0;

  pc_sequencer #(
    .PC_W      (6),
    .RESET_VEC (6'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_i       (run_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .instr_vld_o (instr_vld_o),
    .exec_done_i (exec_done_i),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_tgt_i    (br_tgt_i),
    .halt_i      (halt_i),
`ifdef PC_SEQ_LINK_EN
    .call_i      (call_i),
    .ret_i       (ret_i),
`endif
    .pc_o        (pc_o),
    .halted_o    (halted_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request, compare it with the scoreboard head, hold for
  // 'delay' cycles, then acknowledge and confirm the EXEC pulse.
  task automatic do_fetch(input int delay);
    int         n;
    logic [5:0] e;
    n = 0;
    while (imem_req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("fetch_req", imem_req_o, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'bx;
    check("fetch_addr", imem_addr_o, e);
    check("fetch_pc", pc_o, e);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("req_hold", imem_req_o, 1);
      check("addr_hold", imem_addr_o, e);
    end
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    check("instr_vld", instr_vld_o, 1);
    check("req_drop", imem_req_o, 0);
  endtask

  // Retire one instruction; the model computes the next PC independently.
  task automatic do_exec(input logic br, input logic [5:0] tgt, input logic hlt);
    check("pc_stable_exec", pc_o, model_pc);
    if (!hlt) begin
      if (br) model_pc = tgt;
      else    model_pc = model_pc + 6'd1;
      exp_q.push_back(model_pc);
    end
    exec_done_i = 1'b1;
    br_taken_i  = br;
    br_tgt_i    = tgt;
    halt_i      = hlt;
    tick();
    exec_done_i = 1'b0;
    br_taken_i  = 1'b0;
    halt_i      = 1'b0;
    check("vld_single", instr_vld_o, 0);
    check("pc_update", pc_o, model_pc);
    check("halted", halted_o, hlt);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_req", imem_req_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_vld", instr_vld_o, 0);
    check("rst_halted", halted_o, 0);
    rst = 1'b1;
    tick();
    check("idle_req", imem_req_o, 0);

    // 1: sequential fetch/exec 0,1,2,3
    model_pc = 6'd0;
    exp_q.push_back(model_pc);
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    do_fetch(0);
    for (int k = 0; k < 3; k++) begin
      do_exec(1'b0, 6'd0, 1'b0);
      do_fetch(0);
    end

    // 2: wrap 63 -> 0
    do_exec(1'b1, 6'd63, 1'b0);
    do_fetch(0);
    do_exec(1'b0, 6'd0, 1'b0);
    do_fetch(0);

    // 3: branch from 5 to 40, then halt wins over branch at 5
    do_exec(1'b1, 6'd5, 1'b0);
    do_fetch(0);
    do_exec(1'b1, 6'd40, 1'b0);
    do_fetch(0);
    do_exec(1'b1, 6'd5, 1'b0);
    do_fetch(0);
    do_exec(1'b1, 6'd40, 1'b1);
    imem_ack_i  = 1'b1;
    exec_done_i = 1'b1;
    tick();
    imem_ack_i  = 1'b0;
    exec_done_i = 1'b0;
    check("halt_hold", halted_o, 1);
    check("halt_req", imem_req_o, 0);
    check("halt_pc", pc_o, 5);
    model_pc = 6'd0;
    exp_q.push_back(model_pc);
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    check("restart_halted", halted_o, 0);
    check("restart_pc", pc_o, 0);
    do_fetch(0);

    // 4: stall holds the PC for 3 cycles, release 7 -> 8
    do_exec(1'b1, 6'd7, 1'b0);
    do_fetch(0);
    exec_done_i = 1'b1;
    stall_i     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_pc", pc_o, 7);
      check("stall_req", imem_req_o, 0);
    end
    stall_i  = 1'b0;
    model_pc = 6'd8;
    exp_q.push_back(model_pc);
    tick();
    exec_done_i = 1'b0;
    check("unstall_pc", pc_o, 8);
    do_fetch(0);

    // 5: delayed ack, then stray ack/run in EXEC ignored
    do_exec(1'b0, 6'd0, 1'b0);
    do_fetch(4);
    imem_ack_i = 1'b1;
    run_i      = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    run_i      = 1'b0;
    check("stray_req", imem_req_o, 0);
    check("stray_pc", pc_o, 9);
    check("stray_vld", instr_vld_o, 0);
    do_exec(1'b0, 6'd0, 1'b0);
    do_fetch(0);

    // 6: asynchronous reset mid-FETCH at pc 12
    do_exec(1'b1, 6'd12, 1'b0);
    check("pre_rst_req", imem_req_o, 1);
    check("pre_rst_pc", pc_o, 12);
    exp_q.delete();
    #2;
    rst = 1'b0;
    #1;
    check("async_req", imem_req_o, 0);
    check("async_pc", pc_o, 0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_req", imem_req_o, 0);
    check("post_rst_pc", pc_o, 0);
    model_pc = 6'd0;
    exp_q.push_back(model_pc);
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    do_fetch(0);

`ifdef PC_SEQ_LINK_EN
    // call at pc 3 to 20, then return to 4
    do_exec(1'b1, 6'd3, 1'b0);
    do_fetch(0);
    call_i      = 1'b1;
    exec_done_i = 1'b1;
    br_tgt_i    = 6'd20;
    tick();
    call_i      = 1'b0;
    exec_done_i = 1'b0;
    model_pc    = 6'd20;
    check("call_pc", pc_o, model_pc);
    exp_q.push_back(model_pc);
    do_fetch(0);
    ret_i       = 1'b1;
    exec_done_i = 1'b1;
    tick();
    ret_i       = 1'b0;
    exec_done_i = 1'b0;
    model_pc    = 6'd4;
    check("ret_pc", pc_o, model_pc);
    exp_q.push_back(model_pc);
    do_fetch(0);
`else
    do_exec(1'b0, 6'd0, 1'b0);
    do_fetch(0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
